// File: rtl/ring_counter_param.sv
// Width-generic ring / Johnson shift counter with direction, enable, parallel load,
// automatic correction of illegal states and registered wrap / illegal pulses.
module ring_counter_param #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             illegal
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] shifted;
    logic [5:0]       ones;
    logic [5:0]       trans;
    logic             legal;

    // Legality is judged against the mode presented this cycle, so a mode switch
    // onto an incompatible pattern is corrected on the very next edge.
    always_comb begin
        ones  = '0;
        trans = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + 6'(q_q[i]);
        end
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            trans = trans + 6'(q_q[i] ^ q_q[i+1]);
        end
        legal = mode ? (trans <= 6'd1) : (ones == 6'd1);
        seed  = mode ? '0 : WIDTH'(1);
    end

    always_comb begin
        shifted = q_q;
        case ({mode, dir})
            2'b00:   shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            2'b01:   shifted = {q_q[0], q_q[WIDTH-1:1]};
            2'b10:   shifted = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            default: shifted = {~q_q[0], q_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        q_d       = q_q;
        wrap_d    = 1'b0;
        illegal_d = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (!legal) begin
            q_d       = seed;
            illegal_d = 1'b1;
        end else if (en) begin
            q_d    = shifted;
            wrap_d = (shifted == seed);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= WIDTH'(1);
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
        end
    end

    assign q       = q_q;
    assign wrap    = wrap_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench for ring_counter_param: directed scenarios plus a randomized
// run against an arithmetic reference model.
module tb_ring_counter_param;

    localparam int unsigned W = 4;
    localparam int unsigned P = 1 << W;

    logic         clk = 1'b0;
    logic         reset, en, mode, dir, load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         wrap, illegal;

    int unsigned  n_cmp  = 0;
    int unsigned  n_fail = 0;

    ring_counter_param #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned bit_of(int unsigned v, int unsigned i);
        return (v / (1 << i)) % 2;
    endfunction

    function automatic bit model_legal(int unsigned v, bit m);
        int unsigned cnt;
        cnt = 0;
        if (!m) begin
            for (int unsigned i = 0; i < W; i++) cnt += bit_of(v, i);
            return cnt == 1;
        end
        for (int unsigned i = 0; i + 1 < W; i++)
            if (bit_of(v, i) != bit_of(v, i + 1)) cnt++;
        return cnt <= 1;
    endfunction

    // Next value of an enabled step: rotate (ring) or rotate with inverted feedback (Johnson).
    function automatic int unsigned model_shift(int unsigned v, bit m, bit d);
        int unsigned msb, lsb;
        msb = v / (P / 2);
        lsb = v % 2;
        if (!d) return ((v * 2) % P) + (m ? (1 - msb) : msb);
        return (v / 2) + (m ? (1 - lsb) : lsb) * (P / 2);
    endfunction

    task automatic test_reset();
        reset = 1; en = 0; mode = 0; dir = 0; load = 0; load_val = '0;
        step();
        n_cmp++;
        if ({q, wrap, illegal} !== {4'b0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got q=%b wrap=%b illegal=%b, want q=0001 wrap=0 illegal=0", q, wrap, illegal);
        end
        reset = 0;
    endtask

    task automatic test_ring_left();
        logic [W-1:0] exp_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode = 0; dir = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({q, wrap, illegal} !== {exp_q[i], (i == 3), 1'b0}) begin
                n_fail++;
                $display("FAIL ring_left[%0d]: got q=%b wrap=%b illegal=%b, want q=%b wrap=%b illegal=0",
                         i, q, wrap, illegal, exp_q[i], (i == 3));
            end
        end
    endtask

    task automatic test_ring_right_hold();
        logic [W-1:0] exp_q [7] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0001};
        logic         exp_en[7] = '{1, 1, 0, 0, 0, 1, 1};
        reset = 1; step(); reset = 0;
        mode = 0; dir = 1;
        for (int i = 0; i < 7; i++) begin
            en = exp_en[i];
            step();
            n_cmp++;
            if ({q, wrap, illegal} !== {exp_q[i], (i == 6), 1'b0}) begin
                n_fail++;
                $display("FAIL ring_right_hold[%0d]: got q=%b wrap=%b illegal=%b, want q=%b wrap=%b illegal=0",
                         i, q, wrap, illegal, exp_q[i], (i == 6));
            end
        end
    endtask

    task automatic test_johnson();
        logic [W-1:0] exp_q [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
        reset = 1; step(); reset = 0;
        en = 0; mode = 1; dir = 0;
        step();
        n_cmp++;
        if ({q, wrap, illegal} !== {4'b0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL johnson_keep: got q=%b wrap=%b illegal=%b, want q=0001 wrap=0 illegal=0", q, wrap, illegal);
        end
        load = 1; load_val = 4'b0000;
        step();
        load = 0; en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({q, wrap, illegal} !== {exp_q[i], (i == 7), 1'b0}) begin
                n_fail++;
                $display("FAIL johnson_left[%0d]: got q=%b wrap=%b illegal=%b, want q=%b wrap=%b illegal=0",
                         i, q, wrap, illegal, exp_q[i], (i == 7));
            end
        end
        en = 0;
    endtask

    task automatic test_illegal_load();
        logic [W-1:0] vals [2] = '{4'b0110, 4'b0000};
        mode = 0; en = 1;
        for (int i = 0; i < 2; i++) begin
            load = 1; load_val = vals[i];
            step();
            n_cmp++;
            if ({q, wrap, illegal} !== {vals[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL illegal_load_show[%0d]: got q=%b wrap=%b illegal=%b, want q=%b wrap=0 illegal=0",
                         i, q, wrap, illegal, vals[i]);
            end
            load = 0; en = 0;
            step();
            n_cmp++;
            if ({q, wrap, illegal} !== {4'b0001, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL illegal_load_fix[%0d]: got q=%b wrap=%b illegal=%b, want q=0001 wrap=0 illegal=1",
                         i, q, wrap, illegal);
            end
            step();
            n_cmp++;
            if ({q, wrap, illegal} !== {4'b0001, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL illegal_pulse_end[%0d]: got q=%b wrap=%b illegal=%b, want q=0001 wrap=0 illegal=0",
                         i, q, wrap, illegal);
            end
            en = 1;
        end
        en = 0;
    endtask

    task automatic test_mode_switch();
        mode = 0; en = 0; load = 1; load_val = 4'b0100;
        step();
        load = 0; mode = 1;
        step();
        n_cmp++;
        if ({q, wrap, illegal} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mode_to_johnson: got q=%b wrap=%b illegal=%b, want q=0000 wrap=0 illegal=1", q, wrap, illegal);
        end
        mode = 0;
        step();
        n_cmp++;
        if ({q, wrap, illegal} !== {4'b0001, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mode_to_ring: got q=%b wrap=%b illegal=%b, want q=0001 wrap=0 illegal=1", q, wrap, illegal);
        end
    endtask

    task automatic test_reset_priority();
        mode = 1; en = 0; load = 1; load_val = 4'b0111;
        step();
        reset = 1; en = 1; load = 1; load_val = 4'b1010;
        step();
        n_cmp++;
        if ({q, wrap, illegal} !== {4'b0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_over_load: got q=%b wrap=%b illegal=%b, want q=0001 wrap=0 illegal=0", q, wrap, illegal);
        end
        reset = 0; load_val = 4'b0011;
        step();
        n_cmp++;
        if ({q, wrap, illegal} !== {4'b0011, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_over_en: got q=%b wrap=%b illegal=%b, want q=0011 wrap=0 illegal=0", q, wrap, illegal);
        end
        load = 0; en = 0;
    endtask

    task automatic test_random();
        int unsigned mq;
        bit          mw, mi;
        reset = 1; load = 0; en = 0;
        step();
        mq = 1;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom);
            en       = $urandom_range(0, 3) != 0;
            dir      = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            mw = 0; mi = 0;
            if (reset) mq = 1;
            else if (load) mq = load_val;
            else if (!model_legal(mq, mode)) begin
                mq = mode ? 0 : 1;
                mi = 1;
            end else if (en) begin
                mq = model_shift(mq, mode, dir);
                mw = (mq == (mode ? 0 : 1));
            end
            step();
            n_cmp++;
            if ({q, wrap, illegal} !== {W'(mq), mw, mi}) begin
                n_fail++;
                $display("FAIL random[%0d]: got q=%b wrap=%b illegal=%b, want q=%b wrap=%b illegal=%b",
                         i, q, wrap, illegal, W'(mq), mw, mi);
            end
        end
        reset = 0; load = 0; en = 0;
    endtask

    initial begin
        test_reset();
        test_ring_left();
        test_ring_right_hold();
        test_johnson();
        test_illegal_load();
        test_mode_switch();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
